// File: rtl/mips_ex_mem_stage_pkg.sv
// Shared EX/MEM definitions: default field widths, control-bundle bit positions
// and the skid-buffer state encoding.
package mips_ex_mem_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;
  localparam int CTRL_W_DEF = 4;

  // Bit positions inside the {regWrite, memToReg, memRead, memWrite} bundle
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 0;

  // Encoded directly as {mainValid, skidValid}; 2'b01 is unreachable
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_HALF  = 2'b10,
    SKID_FULL  = 2'b11
  } skidState_t;

endpackage

// File: rtl/mips_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer with flush. The head (main) entry drives
// the outputs; inReady depends only on registered state.
module mips_skid_buffer
  import mips_ex_mem_stage_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inData,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outData
);

  skidState_t       stateReg, stateNext;
  logic [WIDTH-1:0] mainReg, skidReg, mainNext;
  logic             loadMain, loadSkid;
  logic             mainValid, skidValid, accept, pop;

  assign mainValid = stateReg[1];
  assign skidValid = stateReg[0];
  assign inReady   = ~skidValid;
  assign outValid  = mainValid;
  assign outData   = mainReg;
  assign accept    = inValid & inReady;
  assign pop       = outValid & outReady;

  always_comb begin
    stateNext = stateReg;
    loadMain  = 1'b0;
    loadSkid  = 1'b0;
    mainNext  = inData;
    if (flush) begin
      stateNext = SKID_EMPTY;
    end else begin
      case (stateReg)
        SKID_EMPTY: if (accept) begin
          stateNext = SKID_HALF;
          loadMain  = 1'b1;
        end
        SKID_HALF: begin
          if (accept && pop) begin
            loadMain = 1'b1;
          end else if (accept) begin
            stateNext = SKID_FULL;
            loadSkid  = 1'b1;
          end else if (pop) begin
            stateNext = SKID_EMPTY;
          end
        end
        SKID_FULL: if (pop) begin
          stateNext = SKID_HALF;
          loadMain  = 1'b1;
          mainNext  = skidReg;
        end
        default: stateNext = SKID_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateReg <= SKID_EMPTY;
      mainReg  <= '0;
      skidReg  <= '0;
    end else begin
      stateReg <= stateNext;
      if (loadMain) mainReg <= mainNext;
      if (loadSkid) skidReg <= inData;
    end
  end

`ifndef SYNTHESIS
  skidImpliesMain: assert property (@(posedge clk) disable iff (!rst_n) skidValid |-> mainValid);
`endif

endmodule

// File: rtl/mips_ex_mem_stage.sv
// EX/MEM pipeline register: sanitises control on capture, buffers through a skid
// buffer and exposes the head entry as a forwarding tap.
module mips_ex_mem_stage
  import mips_ex_mem_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              inValid,
  output logic              inReady,
  input  logic [DATA_W-1:0] inAluResult,
  input  logic              inZero,
  input  logic [DATA_W-1:0] inStoreData,
  input  logic [REG_W-1:0]  inDestReg,
  input  logic [CTRL_W-1:0] inCtrl,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W-1:0] outAluResult,
  output logic              outZero,
  output logic [DATA_W-1:0] outStoreData,
  output logic [REG_W-1:0]  outDestReg,
  output logic [CTRL_W-1:0] outCtrl,
  output logic              fwdValid,
  output logic [REG_W-1:0]  fwdReg,
  output logic [DATA_W-1:0] fwdData
);

  localparam int PACK_W = 2 * DATA_W + 1 + REG_W + CTRL_W;

  logic [CTRL_W-1:0] ctrlSan;
  logic [PACK_W-1:0] packIn, packOut;

  // $zero is never a write target; a load+store combo degrades to a plain load
  always_comb begin
    ctrlSan                = inCtrl;
    ctrlSan[CTRL_REGWRITE] = inCtrl[CTRL_REGWRITE] & (inDestReg != '0);
    ctrlSan[CTRL_MEMWRITE] = inCtrl[CTRL_MEMWRITE] & ~inCtrl[CTRL_MEMREAD];
  end

  assign packIn = {inAluResult, inZero, inStoreData, inDestReg, ctrlSan};

  mips_skid_buffer #(.WIDTH(PACK_W)) skidBuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .inValid  (inValid),
    .inReady  (inReady),
    .inData   (packIn),
    .outValid (outValid),
    .outReady (outReady),
    .outData  (packOut)
  );

  assign {outAluResult, outZero, outStoreData, outDestReg, outCtrl} = packOut;

  assign fwdValid = outValid & outCtrl[CTRL_REGWRITE];
  assign fwdReg   = outDestReg;
  assign fwdData  = outAluResult;

`ifndef SYNTHESIS
  noLoadStore: assert property (@(posedge clk) disable iff (!rst_n)
    (inValid && inReady) |-> !(inCtrl[CTRL_MEMREAD] && inCtrl[CTRL_MEMWRITE]));
`endif

endmodule

// File: tb/tb_mips_ex_mem_stage.sv
// Directed bench for mips_ex_mem_stage: inputs change and outputs are sampled on
// the falling edge, so each step covers exactly one rising edge.
module tb_mips_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, inValid, inReady, inZero, outValid, outReady, outZero, fwdValid;
  logic [31:0] inAluResult, inStoreData, outAluResult, outStoreData, fwdData;
  logic [4:0]  inDestReg, outDestReg, fwdReg;
  logic [3:0]  inCtrl, outCtrl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_ex_mem_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .inValid      (inValid),
    .inReady      (inReady),
    .inAluResult  (inAluResult),
    .inZero       (inZero),
    .inStoreData  (inStoreData),
    .inDestReg    (inDestReg),
    .inCtrl       (inCtrl),
    .outValid     (outValid),
    .outReady     (outReady),
    .outAluResult (outAluResult),
    .outZero      (outZero),
    .outStoreData (outStoreData),
    .outDestReg   (outDestReg),
    .outCtrl      (outCtrl),
    .fwdValid     (fwdValid),
    .fwdReg       (fwdReg),
    .fwdData      (fwdData)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic offer(input logic [31:0] alu, input logic z, input logic [4:0] rd, input logic [3:0] ctrl);
    inValid     = 1'b1;
    inAluResult = alu;
    inZero      = z;
    inStoreData = ~alu;
    inDestReg   = rd;
    inCtrl      = ctrl;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
    inAluResult = '0; inZero = 1'b0; inStoreData = '0; inDestReg = '0; inCtrl = '0;
    step(); step();
    rst_n = 1'b1;
    checkVal("rst_outValid", 32'(outValid), 32'd0);
    checkVal("rst_inReady",  32'(inReady),  32'd1);
    checkVal("rst_fwdValid", 32'(fwdValid), 32'd0);
    checkVal("rst_outAlu",   outAluResult,  32'd0);

    // Streaming: one entry per cycle, each visible one edge after acceptance
    outReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      offer(32'h10 + 32'(i), 1'b0, 5'(i + 1), 4'b1000);
      step();
      checkVal($sformatf("stream%0d_alu", i), outAluResult, 32'h10 + 32'(i));
      checkVal($sformatf("stream%0d_sd", i), outStoreData, ~(32'h10 + 32'(i)));
      checkVal($sformatf("stream%0d_vld_rdy", i), {30'd0, outValid, inReady}, 32'd3);
    end
    inValid = 1'b0;
    step();
    checkVal("stream_drained", 32'(outValid), 32'd0);

    // Backpressure: A held, B skidded, C stalled, then drain in order
    outReady = 1'b0;
    offer(32'hA, 1'b0, 5'd1, 4'b1000); step();
    checkVal("bp_A_head", outAluResult, 32'hA);
    offer(32'hB, 1'b0, 5'd2, 4'b1000); step();
    checkVal("bp_A_held", outAluResult, 32'hA);
    checkVal("bp_full_inReady", 32'(inReady), 32'd0);
    offer(32'hC, 1'b0, 5'd3, 4'b1000); step();
    checkVal("bp_C_stall_head", outAluResult, 32'hA);
    checkVal("bp_C_stall_inReady", 32'(inReady), 32'd0);
    outReady = 1'b1; step();
    checkVal("bp_B_head", outAluResult, 32'hB);
    checkVal("bp_B_destReg", 32'(outDestReg), 32'd2);
    checkVal("bp_B_inReady", 32'(inReady), 32'd1);
    step();
    checkVal("bp_C_head", outAluResult, 32'hC);
    checkVal("bp_C_valid", 32'(outValid), 32'd1);
    inValid = 1'b0; step();
    checkVal("bp_drained", 32'(outValid), 32'd0);

    // Flush in FULL with pop and an offer pending
    outReady = 1'b0;
    offer(32'h21, 1'b0, 5'd4, 4'b1000); step();
    offer(32'h22, 1'b0, 5'd5, 4'b1000); step();
    checkVal("fl_full", 32'(inReady), 32'd0);
    flush = 1'b1; outReady = 1'b1; offer(32'h23, 1'b0, 5'd6, 4'b1000); step();
    checkVal("fl_outValid", 32'(outValid), 32'd0);
    checkVal("fl_inReady", 32'(inReady), 32'd1);
    checkVal("fl_fwdValid", 32'(fwdValid), 32'd0);
    // Flush in HALF with a real same-cycle accept
    flush = 1'b0; outReady = 1'b0; offer(32'h24, 1'b0, 5'd7, 4'b1000); step();
    checkVal("fl_half_head", outAluResult, 32'h24);
    flush = 1'b1; offer(32'h25, 1'b0, 5'd7, 4'b1000); step();
    flush = 1'b0; inValid = 1'b0;
    checkVal("fl_half_outValid", 32'(outValid), 32'd0);
    step();
    checkVal("fl_nothing_returns", 32'(outValid), 32'd0);

    // Reset mid-stream from FULL, with an offer during the reset edge
    outReady = 1'b0;
    offer(32'h31, 1'b0, 5'd8, 4'b1000); step();
    offer(32'h32, 1'b0, 5'd9, 4'b1000); step();
    rst_n = 1'b0; offer(32'h33, 1'b0, 5'd10, 4'b1000); step();
    rst_n = 1'b1; inValid = 1'b0;
    checkVal("mrst_outValid", 32'(outValid), 32'd0);
    checkVal("mrst_inReady", 32'(inReady), 32'd1);
    checkVal("mrst_fwdValid", 32'(fwdValid), 32'd0);
    step();
    checkVal("mrst_discarded", 32'(outValid), 32'd0);

    // Sanitise: $zero destination drops regWrite; a real destination forwards
    offer(32'hDEAD, 1'b0, 5'd0, 4'b1000); step();
    checkVal("san_r0_valid", 32'(outValid), 32'd1);
    checkVal("san_r0_ctrl", 32'(outCtrl), 32'h0);
    checkVal("san_r0_fwdValid", 32'(fwdValid), 32'd0);
    outReady = 1'b1; offer(32'hDEAD, 1'b0, 5'd8, 4'b1110); step();
    checkVal("san_r8_ctrl", 32'(outCtrl), 32'hE);
    checkVal("san_r8_fwdValid", 32'(fwdValid), 32'd1);
    checkVal("san_r8_fwdReg", 32'(fwdReg), 32'd8);
    checkVal("san_r8_fwdData", fwdData, 32'hDEAD);
    inValid = 1'b0; step();
    checkVal("san_drained_fwd", 32'(fwdValid), 32'd0);

    // Zero flag per entry, second entry passing through the skid slot
    outReady = 1'b0;
    offer(32'h0, 1'b1, 5'd3, 4'b1000); step();
    offer(32'hFFFF_FFFF, 1'b0, 5'd3, 4'b1000); step();
    checkVal("zero_e0_flag", 32'(outZero), 32'd1);
    checkVal("zero_e0_alu", outAluResult, 32'h0);
    inValid = 1'b0; outReady = 1'b1; step();
    checkVal("zero_e1_flag", 32'(outZero), 32'd0);
    checkVal("zero_e1_alu", outAluResult, 32'hFFFF_FFFF);
    step();
    checkVal("zero_drained", 32'(outValid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
